// File: rtl/exp_share_arb.sv
// Round-robin arbiter sharing one external combinational Q6.10 exp unit among N_REQ requesters.
// Optional macro EXP_ARB_SAT_EN saturates out-of-range results at the S2 load.
module exp_share_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 16,
  parameter int ID_W   = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ*DATA_W-1:0]   req_x,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic [ID_W-1:0]           resp_id,
  output logic [DATA_W-1:0]         exp_x,
  input  logic [DATA_W-1:0]         exp_y
);

  localparam logic [ID_W-1:0] LAST_RST = ID_W'(N_REQ - 1);
  localparam logic [ID_W:0]   N_WIDE   = (ID_W + 1)'(N_REQ);

  logic                r_s1_valid;
  logic [DATA_W-1:0]   r_s1_x;
  logic [ID_W-1:0]     r_s1_id;
  logic                r_s2_valid;
  logic [DATA_W-1:0]   r_s2_data;
  logic [ID_W-1:0]     r_s2_id;
  logic [ID_W-1:0]     r_last;

  logic                w_s2_adv;
  logic                w_s1_adv;
  logic                w_found;
  logic [ID_W-1:0]     w_grant;
  logic [ID_W:0]       w_cand;
  logic                w_accept;
  logic [N_REQ-1:0]    w_req_ready;
  logic [DATA_W-1:0]   w_grant_x;
  logic [DATA_W-1:0]   w_s2_next;

  assign w_s2_adv = !r_s2_valid || resp_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;

  // Scan from last+1 upward with an explicit wrap, so non power-of-two N_REQ works.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = {1'b0, r_last} + (ID_W + 1)'(k);
      if (w_cand >= N_WIDE) begin
        w_cand = w_cand - N_WIDE;
      end
      if (!w_found && req_valid[w_cand[ID_W-1:0]]) begin
        w_found = 1'b1;
        w_grant = w_cand[ID_W-1:0];
      end
    end
  end

  assign w_accept  = w_found && w_s1_adv && !rst;
  assign w_grant_x = req_x[int'(w_grant) * DATA_W +: DATA_W];

  always_comb begin
    w_req_ready = '0;
    if (w_accept) begin
      w_req_ready[w_grant] = 1'b1;
    end
  end

  assign req_ready = w_req_ready;

`ifdef EXP_ARB_SAT_EN
  localparam logic signed [DATA_W-1:0] SAT_LO = DATA_W'(16'hE000);
  localparam logic signed [DATA_W-1:0] SAT_HI = DATA_W'(16'h0DDC);

  // Saturation is decided on the operand, not on the exp output.
  always_comb begin
    w_s2_next = exp_y;
    if ($signed(r_s1_x) < SAT_LO) begin
      w_s2_next = '0;
    end else if ($signed(r_s1_x) > SAT_HI) begin
      w_s2_next = DATA_W'(16'h7FFF);
    end
  end
`else
  assign w_s2_next = exp_y;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_x     <= '0;
      r_s1_id    <= '0;
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_id    <= '0;
      r_last     <= LAST_RST;
    end else begin
      if (w_accept) begin
        r_last <= w_grant;
      end
      // S1 is zeroed when it empties so exp_x stays quiet between operations.
      if (w_s1_adv) begin
        r_s1_valid <= w_accept;
        r_s1_x     <= w_accept ? w_grant_x : '0;
        if (w_accept) begin
          r_s1_id <= w_grant;
        end
      end
      if (w_s2_adv) begin
        r_s2_valid <= r_s1_valid;
        if (r_s1_valid) begin
          r_s2_data <= w_s2_next;
          r_s2_id   <= r_s1_id;
        end
      end
    end
  end

  assign exp_x      = r_s1_valid ? r_s1_x : '0;
  assign resp_valid = r_s2_valid;
  assign resp_data  = r_s2_data;
  assign resp_id    = r_s2_id;

endmodule

// File: tb/tb_exp_share_arb.sv
// Directed-vector bench for exp_share_arb with a table-driven stand-in for the external exp unit.
// Saturation expectations follow EXP_ARB_SAT_EN when it is defined for the build.
module tb_exp_share_arb;

  logic        clock;
  logic        reset;
  logic [3:0]  reqValid;
  logic [3:0]  reqReady;
  logic [63:0] reqX;
  logic        respValid;
  logic        respReady;
  logic [15:0] respData;
  logic [1:0]  respId;
  logic [15:0] expX;
  logic [15:0] expY;

  int testsRun;
  int testsFailed;
  int acceptCount;
  int respCount;
  logic [15:0] heldData;
  logic [1:0]  heldId;

  exp_share_arb #(.N_REQ(4), .DATA_W(16)) dut (
    .clk        (clock),
    .rst        (reset),
    .req_valid  (reqValid),
    .req_ready  (reqReady),
    .req_x      (reqX),
    .resp_valid (respValid),
    .resp_ready (respReady),
    .resp_data  (respData),
    .resp_id    (respId),
    .exp_x      (expX),
    .exp_y      (expY)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Stand-in exp: known points are real exp values, out-of-range points are odd markers,
  // anything else maps to a distinct pattern so responses can be matched to operands.
  function automatic logic [15:0] expModel(input logic [15:0] x);
    case (x)
      16'hFC00: expModel = 16'h0179;
      16'h0000: expModel = 16'h0400;
      16'hF800: expModel = 16'h008A;
      16'hD800: expModel = 16'h0001;
      16'h1400: expModel = 16'h7ABC;
      default:  expModel = x ^ 16'h5A5A;
    endcase
  endfunction

  always_comb expY = expModel(expX);

  always @(negedge clock) begin
    if (!reset) begin
      if (|(reqValid & reqReady)) acceptCount++;
      if (respValid && respReady) respCount++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input int id, input logic [15:0] x, input logic [15:0] expData, input string tag);
    reqValid = 4'b0001 << id;
    reqX[id*16 +: 16] = x;
    #1;
    checkOutput({tag, "_ready"}, 32'(reqReady), 32'(4'b0001 << id));
    tick();
    reqValid = '0;
    #1;
    checkOutput({tag, "_s1_valid_low"}, 32'(respValid), 32'd0);
    checkOutput({tag, "_exp_x"}, 32'(expX), 32'(x));
    tick();
    checkOutput({tag, "_valid"}, 32'(respValid), 32'd1);
    checkOutput({tag, "_id"}, 32'(respId), 32'(id));
    checkOutput({tag, "_data"}, 32'(respData), 32'(expData));
    tick();
    checkOutput({tag, "_drained"}, 32'(respValid), 32'd0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    acceptCount = 0;
    respCount   = 0;
    reset     = 1'b1;
    reqValid  = '0;
    reqX      = '0;
    respReady = 1'b1;

    // Reset state, including ready suppression while reset is high.
    tick();
    reqValid = 4'hF;
    #1;
    checkOutput("rst_ready", 32'(reqReady), 32'd0);
    checkOutput("rst_valid", 32'(respValid), 32'd0);
    checkOutput("rst_data", 32'(respData), 32'd0);
    checkOutput("rst_id", 32'(respId), 32'd0);
    checkOutput("rst_exp_x", 32'(expX), 32'd0);
    tick();
    reset    = 1'b0;
    reqValid = '0;
    tick();

    // Single operations; requester 3 last so round robin restarts at 0.
    applyStimulus(0, 16'hFC00, 16'h0179, "exp_m1");
    applyStimulus(3, 16'h0000, 16'h0400, "exp_0");

    // Four requesters streaming: one accept and one response per cycle.
    reqX     = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    reqValid = 4'hF;
    for (int c = 0; c < 11; c++) begin
      if (c == 8) reqValid = '0;
      #1;
      if (c < 8) checkOutput($sformatf("rr_ready_%0d", c), 32'(reqReady), 32'(4'b0001 << (c % 4)));
      if (c >= 2 && c < 10) begin
        checkOutput($sformatf("rr_valid_%0d", c), 32'(respValid), 32'd1);
        checkOutput($sformatf("rr_id_%0d", c), 32'(respId), 32'((c - 2) % 4));
        checkOutput($sformatf("rr_data_%0d", c), 32'(respData),
                    32'(expModel(16'(((c - 2) % 4 + 1) * 256))));
      end
      if (c == 10) checkOutput("rr_idle", 32'(respValid), 32'd0);
      tick();
    end

    // Backpressure: requesters 1 and 2 stream while the response side stalls.
    reqX      = {16'h0000, 16'h2222, 16'h1111, 16'h0000};
    reqValid  = 4'b0110;
    respReady = 1'b0;
    #1;
    checkOutput("bp_ready_0", 32'(reqReady), 32'b0010);
    tick();
    checkOutput("bp_ready_1", 32'(reqReady), 32'b0100);
    tick();
    checkOutput("bp_ready_2", 32'(reqReady), 32'd0);
    checkOutput("bp_valid", 32'(respValid), 32'd1);
    checkOutput("bp_id", 32'(respId), 32'd1);
    checkOutput("bp_data", 32'(respData), 32'(16'h1111 ^ 16'h5A5A));
    heldData = respData;
    heldId   = respId;
    tick();
    checkOutput("bp_ready_3", 32'(reqReady), 32'd0);
    checkOutput("bp_hold_data", 32'(respData), 32'(heldData));
    checkOutput("bp_hold_id", 32'(respId), 32'(heldId));
    respReady = 1'b1;
    reqValid  = '0;
    tick();
    checkOutput("bp_drain_valid", 32'(respValid), 32'd1);
    checkOutput("bp_drain_id", 32'(respId), 32'd2);
    checkOutput("bp_drain_data", 32'(respData), 32'(16'h2222 ^ 16'h5A5A));
    tick();
    checkOutput("bp_drain_done", 32'(respValid), 32'd0);
    checkOutput("accept_total", 32'(acceptCount), 32'd12);
    checkOutput("resp_total", 32'(respCount), 32'd12);

    // Reset with both stages full discards them and restores priority to requester 0.
    respReady = 1'b0;
    reqX      = {16'h3333, 16'h0000, 16'h0000, 16'h0000};
    reqValid  = 4'b1000;
    #1;
    checkOutput("mid_ready_0", 32'(reqReady), 32'b1000);
    tick();
    tick();
    checkOutput("mid_full", 32'(respValid), 32'd1);
    reset = 1'b1;
    reqX  = {16'h3333, 16'h0300, 16'h0200, 16'h0100};
    reqValid = 4'hF;
    #1;
    checkOutput("mid_rst_ready", 32'(reqReady), 32'd0);
    tick();
    reset     = 1'b0;
    respReady = 1'b1;
    #1;
    checkOutput("mid_valid_clr", 32'(respValid), 32'd0);
    checkOutput("mid_exp_x_clr", 32'(expX), 32'd0);
    checkOutput("mid_grant0", 32'(reqReady), 32'b0001);
    tick();
    reqValid = '0;
    #1;
    checkOutput("mid_no_stale", 32'(respValid), 32'd0);
    tick();
    checkOutput("mid_first_id", 32'(respId), 32'd0);
    checkOutput("mid_first_data", 32'(respData), 32'(16'h0100 ^ 16'h5A5A));
    tick();

    // Saturation boundary operands.
`ifdef EXP_ARB_SAT_EN
    applyStimulus(0, 16'hD800, 16'h0000, "sat_lo");
    applyStimulus(0, 16'h1400, 16'h7FFF, "sat_hi");
`else
    applyStimulus(0, 16'hD800, 16'h0001, "sat_lo");
    applyStimulus(0, 16'h1400, 16'h7ABC, "sat_hi");
`endif
    applyStimulus(0, 16'hF800, 16'h008A, "sat_mid");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
